sysid_regs: RTL and testbench

- Parameterised system-identification slave, next generation of the single-word read-only sysid.
- Sits on the processor's Avalon-MM data master as a small register block.
- Provides build ID, build timestamp, a snapshot-coherent free-running uptime counter, a read/write scratch register and a capabilities word.
- Reads are pipelined with configurable latency and signalled with readdatavalid.

---
 rtl/sysid_regs.sv | 123 ++++++++++++
 tb/tb_sysid_regs.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sysid_regs.sv
// sysid_regs: Avalon-MM system identification block (ID, timestamp, uptime, scratch, caps).
// Optional macro SYSID_CLEAR_EN: a write to UPTIME_LO with byteenable[0] clears the uptime counter.
module sysid_regs #(
    parameter logic [31:0] ID_VALUE      = 32'hCAFE_0001,
    parameter logic [31:0] TIMESTAMP     = 32'h0000_0000,
    parameter int          CNT_W         = 48,
    parameter int          READ_LATENCY  = 1,
    parameter logic [31:0] SCRATCH_RESET = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        readdatavalid
);
    localparam int HI_W = CNT_W - 32;
`ifdef SYSID_CLEAR_EN
    localparam logic CLEAR_EN = 1'b1;
`else
    localparam logic CLEAR_EN = 1'b0;
`endif
    localparam logic [7:0]  CAP_CNT_W = 8'(CNT_W);
    localparam logic [1:0]  CAP_LAT   = 2'(READ_LATENCY);
    localparam logic [31:0] CAPS      = {15'd0, CLEAR_EN, 6'd0, CAP_LAT, CAP_CNT_W};

    logic [CNT_W-1:0] uptime_q, uptime_d;
    logic [HI_W-1:0]  hi_snap_q, hi_snap_d;
    logic [31:0]      scratch_q, scratch_d;
    logic [31:0]      hi_ext;
    logic [31:0]      rdata_p0;
    logic             clear_hit;
    logic [31:0]      rdata_p1_q, rdata_p1_d;
    logic             vld_p1_q, vld_p1_d;

    always_comb begin
        clear_hit = 1'b0;
`ifdef SYSID_CLEAR_EN
        clear_hit = write && (address == 3'd2) && byteenable[0];
`endif
        uptime_d = clear_hit ? '0 : uptime_q + CNT_W'(1);

        // The LO read and the HI snapshot come from the same pre-increment sample.
        hi_snap_d = hi_snap_q;
        if (read && (address == 3'd2)) begin
            hi_snap_d = uptime_q[CNT_W-1:32];
        end

        scratch_d = scratch_q;
        if (write && (address == 3'd4)) begin
            for (int k = 0; k < 4; k++) begin
                if (byteenable[k]) begin
                    scratch_d[8*k +: 8] = writedata[8*k +: 8];
                end
            end
        end

        hi_ext = '0;
        hi_ext[HI_W-1:0] = hi_snap_q;

        // Mux reads registered state only, so a same-cycle write is seen by the next read.
        case (address)
            3'd0:    rdata_p0 = ID_VALUE;
            3'd1:    rdata_p0 = TIMESTAMP;
            3'd2:    rdata_p0 = uptime_q[31:0];
            3'd3:    rdata_p0 = hi_ext;
            3'd4:    rdata_p0 = scratch_q;
            3'd5:    rdata_p0 = CAPS;
            default: rdata_p0 = '0;
        endcase

        vld_p1_d   = read;
        rdata_p1_d = read ? rdata_p0 : rdata_p1_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            uptime_q   <= '0;
            hi_snap_q  <= '0;
            scratch_q  <= SCRATCH_RESET;
            rdata_p1_q <= '0;
            vld_p1_q   <= 1'b0;
        end else begin
            uptime_q   <= uptime_d;
            hi_snap_q  <= hi_snap_d;
            scratch_q  <= scratch_d;
            rdata_p1_q <= rdata_p1_d;
            vld_p1_q   <= vld_p1_d;
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic [31:0] rdata_p2_q, rdata_p2_d;
            logic        vld_p2_q, vld_p2_d;

            // Stage 2: extra register, data held while no response is in flight.
            always_comb begin
                vld_p2_d   = vld_p1_q;
                rdata_p2_d = vld_p1_q ? rdata_p1_q : rdata_p2_q;
            end

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    rdata_p2_q <= '0;
                    vld_p2_q   <= 1'b0;
                end else begin
                    rdata_p2_q <= rdata_p2_d;
                    vld_p2_q   <= vld_p2_d;
                end
            end

            assign readdata      = rdata_p2_q;
            assign readdatavalid = vld_p2_q;
        end else begin : g_lat1
            assign readdata      = rdata_p1_q;
            assign readdatavalid = vld_p1_q;
        end
    endgenerate
endmodule

// File: tb/tb_sysid_regs.sv
// Directed self-checking bench for sysid_regs: three instances (48b/lat1, 48b/lat2, 33b/lat1).
`timescale 1ns/1ps
module tb_sysid_regs;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = '0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic [3:0]  byteenable = '0;
    logic [31:0] rd_a, rd_b, rd_c;
    logic        rdv_a, rdv_b, rdv_c;
    logic [63:0] up_model;
    int          checks = 0;
    int          errors = 0;

    localparam logic [31:0] TS_A = 32'h6512_3456;
    localparam logic [31:0] SCR_A = 32'hA5A5_0F0F;
`ifdef SYSID_CLEAR_EN
    localparam logic [31:0] CAP_CLR = 32'h0001_0000;
`else
    localparam logic [31:0] CAP_CLR = 32'h0000_0000;
`endif

    always #5 clock = ~clock;

    sysid_regs #(.TIMESTAMP(TS_A), .SCRATCH_RESET(SCR_A)) dut_a (
        .clock(clock), .reset_n(reset_n), .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable), .readdata(rd_a), .readdatavalid(rdv_a));
    sysid_regs #(.READ_LATENCY(2)) dut_b (
        .clock(clock), .reset_n(reset_n), .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable), .readdata(rd_b), .readdatavalid(rdv_b));
    sysid_regs #(.CNT_W(33)) dut_c (
        .clock(clock), .reset_n(reset_n), .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable), .readdata(rd_c), .readdatavalid(rdv_c));

    // Reference uptime for the 48-bit instances: pre-increment value visible at each negedge.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) up_model <= '0;
`ifdef SYSID_CLEAR_EN
        else if (write && address == 3'd2 && byteenable[0]) up_model <= '0;
`endif
        else up_model <= up_model + 64'd1;
    end

    task automatic idle();
        read = 1'b0; write = 1'b0; address = '0; writedata = '0; byteenable = '0;
    endtask

    task automatic step();
        idle();
        @(negedge clock);
    endtask

    task automatic issue(input logic [2:0] a);
        address = a; read = 1'b1;
        @(negedge clock);
        idle();
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
        address = a; writedata = d; byteenable = be; write = 1'b1;
        @(negedge clock);
        idle();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; idle();
        repeat (2) @(negedge clock);
        checks++;
        if (rd_a !== 32'h0 || rdv_a !== 1'b0 || rd_b !== 32'h0 || rdv_b !== 1'b0 || rdv_c !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got a=%h/%b b=%h/%b c_vld=%b, expected all zero", rd_a, rdv_a, rd_b, rdv_b, rdv_c);
        end
        reset_n = 1'b1;
        issue(3'd2);
        checks++;
        if (rdv_a !== 1'b1 || rd_a !== 32'h0 || rd_c !== 32'h0) begin
            errors++;
            $display("FAIL first_uptime: got a=%h/%b c=%h, expected 0 with valid", rd_a, rdv_a, rd_c);
        end
        issue(3'd3);
        checks++;
        if (rd_a !== 32'h0 || rd_c !== 32'h0) begin
            errors++;
            $display("FAIL reset_hi_snap: got a=%h c=%h, expected 0", rd_a, rd_c);
        end
        issue(3'd4);
        checks++;
        if (rd_a !== SCR_A || rd_c !== 32'h0) begin
            errors++;
            $display("FAIL reset_scratch: got a=%h c=%h, expected %h / 0", rd_a, rd_c, SCR_A);
        end
    endtask

    task automatic test_id_caps();
        issue(3'd0);
        checks++;
        if (rdv_a !== 1'b1 || rd_a !== 32'hCAFE_0001) begin
            errors++;
            $display("FAIL id_read: got %h/%b, expected cafe0001/1", rd_a, rdv_a);
        end
        step();
        checks++;
        if (rdv_a !== 1'b0 || rd_a !== 32'hCAFE_0001 || rdv_b !== 1'b1 || rd_b !== 32'hCAFE_0001) begin
            errors++;
            $display("FAIL id_one_cycle: got a=%h/%b b=%h/%b, expected a held no-valid, b cafe0001 valid", rd_a, rdv_a, rd_b, rdv_b);
        end
        issue(3'd1);
        checks++;
        if (rdv_a !== 1'b1 || rd_a !== TS_A) begin
            errors++;
            $display("FAIL timestamp_read: got %h/%b, expected %h/1", rd_a, rdv_a, TS_A);
        end
        issue(3'd5);
        checks++;
        if (rd_a !== (32'h0000_0130 | CAP_CLR) || rd_c !== (32'h0000_0121 | CAP_CLR)) begin
            errors++;
            $display("FAIL caps_lat1: got a=%h c=%h, expected %h / %h", rd_a, rd_c, 32'h130 | CAP_CLR, 32'h121 | CAP_CLR);
        end
        step();
        checks++;
        if (rdv_b !== 1'b1 || rd_b !== (32'h0000_0230 | CAP_CLR)) begin
            errors++;
            $display("FAIL caps_lat2: got %h/%b, expected %h/1", rd_b, rdv_b, 32'h230 | CAP_CLR);
        end
        issue(3'd6);
        checks++;
        if (rdv_a !== 1'b1 || rd_a !== 32'h0) begin
            errors++;
            $display("FAIL unused_addr: got %h/%b, expected 0/1", rd_a, rdv_a);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp[5];
        exp[0] = 32'hCAFE_0001; exp[1] = 32'h0; exp[2] = 32'h0; exp[3] = 32'h0; exp[4] = 32'h0;
        step();
        for (int k = 0; k < 8; k++) begin
            if (k < 5) begin
                address = 3'(k); read = 1'b1;
                if (k == 2) exp[2] = up_model[31:0];
            end else begin
                idle();
            end
            @(negedge clock);
            checks++;
            if (k >= 1 && k <= 5) begin
                if (rdv_b !== 1'b1 || rd_b !== exp[k-1]) begin
                    errors++;
                    $display("FAIL b2b_resp%0d: got %h/%b, expected %h/1", k - 1, rd_b, rdv_b, exp[k-1]);
                end
            end else if (rdv_b !== 1'b0) begin
                errors++;
                $display("FAIL b2b_gap%0d: got valid=%b, expected 0", k, rdv_b);
            end
        end
        idle();
    endtask

    task automatic test_scratch();
        wr(3'd4, 32'h1234_5678, 4'hF);
        wr(3'd4, 32'hAABB_CCDD, 4'b0101);
        wr(3'd4, 32'hFFFF_FFFF, 4'h0);
        issue(3'd4);
        checks++;
        if (rd_a !== 32'h12BB_56DD || rd_c !== 32'h12BB_56DD) begin
            errors++;
            $display("FAIL scratch_bytes: got a=%h c=%h, expected 12bb56dd", rd_a, rd_c);
        end
        wr(3'd4, 32'h0000_0000, 4'b1000);
        issue(3'd4);
        checks++;
        if (rd_a !== 32'h00BB_56DD) begin
            errors++;
            $display("FAIL scratch_top_lane: got %h, expected 00bb56dd", rd_a);
        end
    endtask

    task automatic test_rw_same();
        wr(3'd4, 32'h0, 4'hF);
        address = 3'd4; read = 1'b1; write = 1'b1; writedata = 32'h0000_00FF; byteenable = 4'hF;
        @(negedge clock);
        idle();
        checks++;
        if (rdv_a !== 1'b1 || rd_a !== 32'h0) begin
            errors++;
            $display("FAIL rw_old_value: got %h/%b, expected 0/1", rd_a, rdv_a);
        end
        issue(3'd4);
        checks++;
        if (rd_a !== 32'h0000_00FF) begin
            errors++;
            $display("FAIL rw_new_value: got %h, expected 000000ff", rd_a);
        end
        wr(3'd0, 32'hFFFF_FFFF, 4'hF);
        wr(3'd5, 32'hFFFF_FFFF, 4'hF);
        issue(3'd0);
        checks++;
        if (rd_a !== 32'hCAFE_0001) begin
            errors++;
            $display("FAIL id_readonly: got %h, expected cafe0001", rd_a);
        end
        issue(3'd5);
        checks++;
        if (rd_a !== (32'h0000_0130 | CAP_CLR)) begin
            errors++;
            $display("FAIL caps_readonly: got %h, expected %h", rd_a, 32'h130 | CAP_CLR);
        end
    endtask

    task automatic test_clear();
        logic [31:0] expv;
        repeat (100) step();
        wr(3'd2, 32'h0, 4'h1);
`ifdef SYSID_CLEAR_EN
        expv = 32'h0;
`else
        expv = up_model[31:0];
`endif
        issue(3'd2);
        checks++;
        if (rd_a !== expv || rdv_a !== 1'b1) begin
            errors++;
            $display("FAIL clear_write: got %h/%b, expected %h/1", rd_a, rdv_a, expv);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_c[8];
        exp_c[0] = 32'hFFFF_FFFF; exp_c[1] = 32'h0; exp_c[2] = 32'h2; exp_c[3] = 32'h1;
        exp_c[4] = 32'hFFFF_FFFF; exp_c[5] = 32'h1; exp_c[6] = 32'h1; exp_c[7] = 32'h0;
        for (int k = 0; k < 8; k++) begin
            if (k == 0) dut_c.uptime_q = 33'h0_FFFF_FFFF;
            if (k == 4) dut_c.uptime_q = 33'h1_FFFF_FFFF;
            if (k == 1) step();
            issue((k % 2 == 0) ? 3'd2 : 3'd3);
            checks++;
            if (rdv_c !== 1'b1 || rd_c !== exp_c[k]) begin
                errors++;
                $display("FAIL wrap_%s%0d: got %h/%b, expected %h/1", (k % 2 == 0) ? "lo" : "hi", k, rd_c, rdv_c, exp_c[k]);
            end
        end
    endtask

    task automatic test_reset_mid_read();
        logic seen;
        address = 3'd0; read = 1'b1;
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        idle();
        @(negedge clock);
        checks++;
        if (rdv_a !== 1'b0 || rdv_b !== 1'b0 || rdv_c !== 1'b0 || rd_a !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_read: got vld a/b/c=%b%b%b rd_a=%h, expected 000 and 0", rdv_a, rdv_b, rdv_c, rd_a);
        end
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clock);
            if (rdv_a || rdv_b || rdv_c) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL stale_response: got a valid after reset release, expected none");
        end
        issue(3'd4);
        checks++;
        if (rd_a !== SCR_A) begin
            errors++;
            $display("FAIL scratch_rereset: got %h, expected %h", rd_a, SCR_A);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        test_reset();
        test_id_caps();
        test_back_to_back();
        test_scratch();
        test_rw_same();
        test_clear();
        test_wrap();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
